// File: rtl/lif_scheduler.sv
`timescale 1ns/1ps
// lif_scheduler: a sweep scheduler for time-multiplexed leaky integrate-and-fire
// neurons. Each sweep updates every neuron once, one per cycle. Spike ids are
// queued in a first-word-fall-through event FIFO. A sticky flag records any
// event dropped because the FIFO was full.
module lif_scheduler #(
  parameter int         NUM_NEURONS = 4,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] THRESH_INIT = 8'd200
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           cfg_we,
  input  logic [3:0]                     cfg_addr,
  input  logic [7:0]                     cfg_data,
  output logic                           busy,
  output logic                           sweep_done,
  output logic                           ev_valid,
  output logic [$clog2(NUM_NEURONS)-1:0] ev_id,
  input  logic                           ev_ready,
  output logic                           overflow,
  input  logic [$clog2(NUM_NEURONS)-1:0] mon_sel,
  output logic [7:0]                     mon_state
);

  localparam int IDW = $clog2(NUM_NEURONS);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [3:0] ADDR_THRESH = 4'd8;
  localparam logic [3:0] ADDR_CLR    = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_e;

  fsm_e           fsm_q;
  logic [IDW-1:0] idx_q;
  logic           busy_q;
  logic           sweep_done_q;

  logic [7:0] v_q   [NUM_NEURONS];
  logic [7:0] cur_q [NUM_NEURONS];
  logic [7:0] thresh_q;

  logic [IDW-1:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           ovf_q;

  logic       spike;
  logic [8:0] sum;
  logic [7:0] v_d;
  logic       fifo_full, fifo_empty, pop, push, drop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Membrane update for the neuron currently addressed by the sweep.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    spike = 1'b0;
    sum   = '0;
    v_d   = '0;
    if (fsm_q == S_RUN) begin
      spike = (v_q[idx_q] >= thresh_q);
      sum   = {1'b0, cur_q[idx_q]} + {2'b00, v_q[idx_q][7:1]};
      v_d   = spike ? 8'h00 : (sum[8] ? 8'hFF : sum[7:0]);
    end
  end

  // Sweep sequencer with registered busy/sweep_done.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      fsm_q        <= S_IDLE;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (start) begin
            fsm_q  <= S_RUN;
            idx_q  <= '0;
            busy_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (idx_q == IDW'(NUM_NEURONS - 1)) begin
            fsm_q        <= S_DONE;
            idx_q        <= '0;
            sweep_done_q <= 1'b1;
          end else begin
            idx_q <= idx_q + IDW'(1);
          end
        end
        S_DONE: begin
          fsm_q        <= S_IDLE;
          busy_q       <= 1'b0;
          sweep_done_q <= 1'b0;
        end
        default: begin
          fsm_q        <= S_IDLE;
          busy_q       <= 1'b0;
          sweep_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Membrane state array: one neuron written per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the membrane array is reset because mon_state must read 0 out of reset;
    // the event FIFO storage below is left unreset since ev_id is gated by ev_valid.
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) v_q[i] <= '0;
    end else if (fsm_q == S_RUN) begin
      v_q[idx_q] <= v_d;
    end
  end

  // Configuration registers: per-neuron currents and the shared threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) cur_q[i] <= '0;
      thresh_q <= THRESH_INIT;
    end else if (cfg_we) begin
      if (cfg_addr < 4'(NUM_NEURONS)) cur_q[cfg_addr[IDW-1:0]] <= cfg_data;
      else if (cfg_addr == ADDR_THRESH) thresh_q <= cfg_data;
    end
  end

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty && ev_ready;
  assign push       = spike && (!fifo_full || pop);
  assign drop       = spike && fifo_full && !pop;

  // Event FIFO storage.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= idx_q;
  end

  // Event FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle wins over a clear write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (cfg_we && (cfg_addr == ADDR_CLR)) begin
      ovf_q <= 1'b0;
    end
  end

  assign busy       = busy_q;
  assign sweep_done = sweep_done_q;
  assign ev_valid   = !fifo_empty;
  assign ev_id      = fifo_empty ? '0 : fifo_q[rd_ptr_q];
  assign overflow   = ovf_q;
  assign mon_state  = v_q[mon_sel];

endmodule

// File: tb/tb_lif_scheduler.sv
`timescale 1ns/1ps
// Directed testbench for lif_scheduler (default parameters: 4 neurons, 4-entry FIFO).
module tb_lif_scheduler;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       busy;
  logic       sweep_done;
  logic       ev_valid;
  logic [1:0] ev_id;
  logic       ev_ready;
  logic       overflow;
  logic [1:0] mon_sel;
  logic [7:0] mon_state;

  int total = 0;
  int bad   = 0;

  lif_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .busy       (busy),
    .sweep_done (sweep_done),
    .ev_valid   (ev_valid),
    .ev_id      (ev_id),
    .ev_ready   (ev_ready),
    .overflow   (overflow),
    .mon_sel    (mon_sel),
    .mon_state  (mon_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [7:0] data);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic do_reset();
    start    = 1'b0;
    cfg_we   = 1'b0;
    ev_ready = 1'b0;
    mon_sel  = '0;
    rst_n    = 1'b0;
    #2;
    rst_n    = 1'b1;
    tick();
  endtask

  task automatic run_sweep(input string tag);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!sweep_done && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, sweep_done, 1);
    tick();
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_at;
    int k;
    logic [1:0] exp_pop [8];

    rst_n    = 1'b0;
    start    = 1'b0;
    cfg_we   = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    ev_ready = 1'b0;
    mon_sel  = '0;
    #12;
    rst_n = 1'b1;
    #1;

    // Reset values.
    check("rst_busy", busy, 0);
    check("rst_sweep_done", sweep_done, 0);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_ev_id", ev_id, 0);
    check("rst_overflow", overflow, 0);
    check("rst_mon_state", mon_state, 0);

    // Leak/integrate: current 100 gives 100, 150, 175 with no spikes.
    do_reset();
    cfg_write(4'd0, 8'd100);
    mon_sel = 2'd0;
    run_sweep("leak1");
    check("leak_s1", mon_state, 100);
    check("leak_ev1", ev_valid, 0);
    run_sweep("leak2");
    check("leak_s2", mon_state, 150);
    run_sweep("leak3");
    check("leak_s3", mon_state, 175);
    check("leak_ev3", ev_valid, 0);

    // Saturation and spike: current 255 on neuron 1, threshold 200.
    do_reset();
    cfg_write(4'd1, 8'd255);
    mon_sel = 2'd1;
    run_sweep("sat1");
    check("sat_s1", mon_state, 255);
    check("sat_ev1", ev_valid, 0);
    run_sweep("sat2");
    check("spk_s2", mon_state, 0);
    check("spk_ev_valid", ev_valid, 1);
    check("spk_ev_id", ev_id, 1);
    run_sweep("sat3");
    check("sat_s3", mon_state, 255);
    check("sat3_ev_id", ev_id, 1);
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    check("pop_empty", ev_valid, 0);

    // Busy window, single sweep_done pulse, start ignored while busy.
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    for (int c = 0; c < 20; c++) begin
      if (!busy) break;
      busy_cnt++;
      if (sweep_done) begin
        done_cnt++;
        done_at = c;
      end
      start = (c == 1);
      tick();
    end
    start = 1'b0;
    check("busy_cycles", busy_cnt, 5);
    check("done_pulses", done_cnt, 1);
    check("done_position", done_at, 4);
    tick();
    check("no_requeue_busy", busy, 0);
    tick();
    check("no_requeue_busy2", busy, 0);

    // FIFO fill and overflow with ev_ready held low.
    do_reset();
    for (int i = 0; i < 4; i++) cfg_write(4'(i), 8'd255);
    cfg_write(4'd8, 8'd0);
    run_sweep("ovf1");
    check("fill_ev_valid", ev_valid, 1);
    check("fill_head", ev_id, 0);
    check("fill_no_ovf", overflow, 0);
    run_sweep("ovf2");
    check("drop_ovf", overflow, 1);
    check("drop_head", ev_id, 0);
    cfg_write(4'd9, 8'd0);
    check("clr_ovf", overflow, 0);
    // Clear written on every cycle of a dropping sweep: the set wins.
    start    = 1'b1;
    cfg_we   = 1'b1;
    cfg_addr = 4'd9;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("set_beats_clr", overflow, 1);
    cfg_we = 1'b0;
    tick();
    check("set_sticky", overflow, 1);
    cfg_write(4'd9, 8'd0);
    check("clr_ovf2", overflow, 0);
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", ev_valid, 1);
      check("drain_id", ev_id, 32'(i));
      tick();
    end
    ev_ready = 1'b0;
    check("drain_empty", ev_valid, 0);

    // Full FIFO with concurrent pops: no drops, FIFO order kept.
    do_reset();
    for (int i = 0; i < 4; i++) cfg_write(4'(i), 8'd255);
    cfg_write(4'd8, 8'd0);
    run_sweep("pp1");
    check("pp_full_head", ev_id, 0);
    exp_pop = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    start = 1'b1;
    tick();
    start    = 1'b0;
    ev_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 20 && k < 8; c++) begin
      if (ev_valid) begin
        check("pp_order", ev_id, 32'(exp_pop[k]));
        k++;
      end
      tick();
    end
    ev_ready = 1'b0;
    check("pp_pop_count", k, 8);
    check("pp_no_ovf", overflow, 0);
    check("pp_empty", ev_valid, 0);

    // Reset in the middle of a sweep.
    do_reset();
    for (int i = 0; i < 4; i++) cfg_write(4'(i), 8'd255);
    run_sweep("mid1");
    mon_sel = 2'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mid_busy", busy, 1);
    check("mid_ev_valid", ev_valid, 1);
    check("mid_mon", mon_state, 255);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_sweep_done", sweep_done, 0);
    check("arst_ev_valid", ev_valid, 0);
    check("arst_ev_id", ev_id, 0);
    check("arst_overflow", overflow, 0);
    check("arst_mon", mon_state, 0);
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      mon_sel = 2'(i);
      #1;
      check("post_rst_mon", mon_state, 0);
    end
    check("post_rst_busy", busy, 0);
    check("post_rst_ev_valid", ev_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
